// File: rtl/io_uart_tx_port_pkg.sv
// Shared register map, STATUS bit layout and serialiser state encoding
// for the IO-bus UART transmitter.
package io_uart_pkg;

    // Register select, taken from io_address[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_BAUD   = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS register bit positions
    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_EMPTY   = 2;
    localparam int ST_OVF     = 3;
    localparam int ST_CNT_LSB = 4;
    localparam int ST_CNT_W   = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/io_uart_tx_port_if.sv
// Processor IO bus as seen by one responder. The core is the master;
// io_read_value and io_hit come back from the responder combinationally.
interface io_uart_tx_port_if;
    logic [31:0] io_address;
    logic [31:0] io_write_value;
    logic [31:0] io_read_value;
    logic        io_write_en;
    logic        io_read_en;
    logic        io_hit;

    modport master (
        output io_address, io_write_value, io_write_en, io_read_en,
        input  io_read_value, io_hit
    );

    modport slave (
        input  io_address, io_write_value, io_write_en, io_read_en,
        output io_read_value, io_hit
    );
endinterface

// File: rtl/io_uart_tx_port_fifo.sv
// Small synchronous FIFO. A push while full is dropped even if a pop
// happens on the same edge, so the caller can flag it as an overflow.
module io_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_FULL);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    // Next storage, pointers and occupancy; pointers wrap naturally (power-of-2 depth)
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CNT_ONE;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CNT_ONE;
        end
    end

    // FIFO state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/io_uart_tx_port.sv
// IO-bus UART transmitter: register decode, TX FIFO and 8N1 serialiser.
//
//   state   | meaning
//   --------+-------------------------------------------------------
//   S_IDLE  | line high; pops the next byte as soon as FIFO non-empty
//   S_START | start bit (line low) for BAUD_DIV+1 clocks
//   S_DATA  | data bits LSB first, bit_idx 0..7, BAUD_DIV+1 clocks each
//   S_STOP  | stop bit (line high) for BAUD_DIV+1 clocks
module io_uart_tx_port
    import io_uart_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
    parameter int          DEPTH       = 4,
    parameter logic [15:0] DEFAULT_DIV = 16'd433
) (
    input  logic              clk,
    input  logic              rst_n,
    io_uart_tx_port_if.slave  bus,
    output logic              uart_tx,
    output logic              tx_empty_irq
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic [1:0]    reg_sel;
    logic          wr_hit, data_push, bit_done;
    logic          fifo_pop, fifo_full, fifo_empty;
    logic [7:0]    fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic [31:0]   rdata;
    logic          unused_bits;

    tx_state_e     state_q, state_d;
    logic [15:0]   baud_q, baud_d, bit_cnt_q, bit_cnt_d;
    logic [2:0]    bit_idx_q, bit_idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d, ovf_q, ovf_d;

    assign bus.io_hit   = (bus.io_address[31:4] == BASE_ADDR[31:4]);
    assign reg_sel      = bus.io_address[3:2];
    assign wr_hit       = bus.io_write_en && bus.io_hit;
    assign data_push    = wr_hit && (reg_sel == REG_DATA);
    assign bit_done     = (bit_cnt_q == '0);
    assign uart_tx      = tx_q;
    assign tx_empty_irq = fifo_empty && (state_q == S_IDLE);
    assign unused_bits  = ^{bus.io_write_value[31:16], bus.io_address[1:0]};

    io_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (data_push),
        .pop   (fifo_pop),
        .wdata (bus.io_write_value[7:0]),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Zero-latency read mux; unselected or missed reads return zero
    always_comb begin
        rdata = '0;
        if (bus.io_read_en && bus.io_hit) begin
            case (reg_sel)
                REG_STATUS: begin
                    rdata[ST_BUSY]  = (state_q != S_IDLE);
                    rdata[ST_FULL]  = fifo_full;
                    rdata[ST_EMPTY] = fifo_empty;
                    rdata[ST_OVF]   = ovf_q;
                    rdata[ST_CNT_LSB +: ST_CNT_W] = ST_CNT_W'(fifo_count);
                end
                REG_BAUD: rdata[15:0] = baud_q;
                default:  rdata = '0;
            endcase
        end
    end
    assign bus.io_read_value = rdata;

    // Register writes: sticky overflow on dropped push, W1C clear, divisor update
    always_comb begin
        ovf_d  = ovf_q;
        baud_d = baud_q;
        if (wr_hit) begin
            case (reg_sel)
                REG_DATA:   if (fifo_full) ovf_d = 1'b1;
                REG_STATUS: if (bus.io_write_value[ST_OVF]) ovf_d = 1'b0;
                REG_BAUD:   baud_d = bus.io_write_value[15:0];
                default:    ovf_d = ovf_q;
            endcase
        end
    end

    // Serialiser next state; each bit reloads the divisor so a new value lands on the next boundary
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        fifo_pop  = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    shift_d   = fifo_rdata;
                    bit_cnt_d = baud_q;
                    tx_d      = 1'b0;
                    state_d   = S_START;
                end
            end
            S_START: begin
                if (bit_done) begin
                    bit_cnt_d = baud_q;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    state_d   = S_DATA;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            S_DATA: begin
                if (bit_done) begin
                    bit_cnt_d = baud_q;
                    if (bit_idx_q == 3'd7) begin
                        tx_d    = 1'b1;
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            S_STOP: begin
                if (bit_done) begin
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    bit_cnt_d = bit_cnt_q - 16'd1;
                end
            end
            default: begin
                tx_d    = 1'b1;
                state_d = S_IDLE;
            end
        endcase
    end

    // Control and datapath registers; line forced high by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            baud_q    <= DEFAULT_DIV;
            bit_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            baud_q    <= baud_d;
            bit_cnt_q <= bit_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ovf_q     <= ovf_d;
        end
    end

endmodule

// File: tb/tb_io_uart_tx_port.sv
// Bench for io_uart_tx_port: a transaction-level model predicts FIFO
// acceptance, status and frame timing; accepted bytes go into a queue
// that a line monitor drains as it decodes frames off uart_tx.
module tb_io_uart_tx_port;

    localparam logic [31:0] BASE    = 32'h0000_1000;
    localparam logic [31:0] A_DATA  = BASE + 32'h0;
    localparam logic [31:0] A_STAT  = BASE + 32'h4;
    localparam logic [31:0] A_BAUD  = BASE + 32'h8;
    localparam logic [31:0] A_RSV   = BASE + 32'hC;
    localparam int          DEPTH   = 4;
    localparam logic [15:0] DEF_DIV = 16'd433;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic uart_tx, irq;

    io_uart_tx_port_if bus();

    io_uart_tx_port #(
        .BASE_ADDR   (BASE),
        .DEPTH       (DEPTH),
        .DEFAULT_DIV (DEF_DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus),
        .uart_tx      (uart_tx),
        .tx_empty_irq (irq)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: occupancy, sticky overflow, divisor and the edge from which
    // the serialiser can take the next byte (a frame is 10 bit slots of
    // div+1 clocks plus one idle clock before the next pop).
    int        m_cyc      = 0;
    int        m_count    = 0;
    int        m_free_at  = 0;
    int        m_last_pop = 0;
    int        m_baud     = int'(DEF_DIV);
    bit        m_ovf      = 1'b0;
    logic [7:0] exp_q[$];
    int        frame_starts[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_b(input string nm, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_busy();
        return (m_cyc + 1) < m_free_at;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s      = '0;
        s[0]   = m_busy();
        s[1]   = (m_count == DEPTH);
        s[2]   = (m_count == 0);
        s[3]   = m_ovf;
        s[7:4] = m_count[3:0];
        return s;
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        m_count   = 0;
        m_ovf     = 1'b0;
        m_baud    = int'(DEF_DIV);
        m_free_at = 0;
    endfunction

    function automatic void model_edge(input bit we, input logic [31:0] a, input logic [31:0] d);
        int pre;
        int baud_next;
        bit pop;
        m_cyc++;
        if (!rst_n) return;
        pre       = m_count;
        baud_next = m_baud;
        pop       = (pre > 0) && (m_cyc >= m_free_at);
        if (we && (a[31:4] == BASE[31:4])) begin
            case (a[3:2])
                2'd0: begin
                    if (pre < DEPTH) begin
                        m_count++;
                        exp_q.push_back(d[7:0]);
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
                2'd1: if (d[3]) m_ovf = 1'b0;
                2'd2: baud_next = int'(d[15:0]);
                default: ;
            endcase
        end
        if (pop) begin
            m_count--;
            m_free_at  = m_cyc + 10 * (m_baud + 1) + 1;
            m_last_pop = m_cyc;
        end
        m_baud = baud_next;
    endfunction

    task automatic step(input bit we, input logic [31:0] a, input logic [31:0] d);
        bus.io_write_en    = we;
        bus.io_address     = a;
        bus.io_write_value = d;
        bus.io_read_en     = 1'b0;
        @(posedge clk);
        model_edge(we, a, d);
        #1;
        bus.io_write_en = 1'b0;
        if (rst_n) begin
            chk_b("tx_empty_irq", irq, (m_count == 0) && !m_busy());
            if (!m_busy()) chk_b("tx_idle_high", uart_tx, 1'b1);
        end
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 32'h0);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        step(1'b1, a, d);
    endtask

    task automatic rd(input logic [31:0] a, input logic [31:0] exp, input string nm);
        bus.io_address = a;
        bus.io_read_en = 1'b1;
        #1;
        chk(nm, bus.io_read_value, exp);
        chk_b({nm, "_hit"}, bus.io_hit, a[31:4] == BASE[31:4]);
        bus.io_read_en = 1'b0;
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while ((m_count != 0 || m_busy()) && k < 5000) begin
            idle();
            k++;
        end
        if (k >= 5000) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_idle: timeout with %0d bytes still queued", m_count);
        end
        repeat (3) idle();
    endtask

    // Line monitor: decodes each frame using the divisor in force at the
    // start of every bit, then compares it with the oldest accepted byte
    initial begin : line_monitor
        logic [9:0] bits;
        logic [7:0] exp;
        logic       v;
        bit         bad, abort;
        int         per, start_cyc;
        forever begin
            @(negedge clk);
            if (rst_n && uart_tx === 1'b0) begin
                abort     = 1'b0;
                bad       = 1'b0;
                bits      = '0;
                start_cyc = m_cyc;
                for (int i = 0; i < 10 && !abort; i++) begin
                    per = m_baud + 1;
                    v   = uart_tx;
                    for (int c = 1; c < per; c++) begin
                        @(negedge clk);
                        if (!rst_n) begin
                            abort = 1'b1;
                            break;
                        end
                        if (uart_tx !== v) bad = 1'b1;
                    end
                    bits[i] = v;
                    if (i < 9 && !abort) begin
                        @(negedge clk);
                        if (!rst_n) abort = 1'b1;
                    end
                end
                if (!abort) begin
                    frame_starts.push_back(start_cyc);
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL frame_unexpected: got data %h, nothing queued", bits[8:1]);
                    end else begin
                        exp = exp_q.pop_front();
                        if (bad || bits[0] !== 1'b0 || bits[9] !== 1'b1 || bits[8:1] !== exp) begin
                            n_err++;
                            $display("FAIL frame: got start %b data %h stop %b unstable %0d, expected data %h",
                                     bits[0], bits[8:1], bits[9], bad, exp);
                        end
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int n0, p, nb, gaps, b;
        bus.io_address     = 32'h0;
        bus.io_write_value = 32'h0;
        bus.io_write_en    = 1'b0;
        bus.io_read_en     = 1'b0;
        repeat (3) idle();
        rst_n = 1'b1;

        // Reset values and address decode
        rd(A_STAT, 32'h4, "status_reset");
        chk_b("tx_reset", uart_tx, 1'b1);
        rd(A_BAUD, 32'(DEF_DIV), "baud_reset");
        bus.io_address = A_STAT;
        #1;
        chk("read_en_low", bus.io_read_value, 32'h0);
        rd(32'h0000_2000, 32'h0, "read_foreign");

        // Single 0xA5 frame at 4 clocks per bit
        wr(A_BAUD, 32'd3);
        wr(A_DATA, 32'hA5);
        n0 = m_cyc;
        for (int k = 1; k <= 200; k++) begin
            idle();
            if (k == 5) rd(A_STAT, 32'h5, "status_busy");
            if (irq) break;
        end
        chk("irq_rise_delay", m_cyc - n0, 41);
        wait_idle();

        // Overflow at 1 clock per bit: 6 back-to-back writes, one byte is
        // taken by the serialiser so only the sixth is dropped
        wr(A_BAUD, 32'd0);
        frame_starts.delete();
        for (int i = 1; i <= 6; i++) wr(A_DATA, i);
        rd(A_STAT, 32'h4B, "status_overflow");
        wait_idle();
        chk("frame_count", frame_starts.size(), 5);
        for (int i = 1; i < frame_starts.size(); i++)
            chk("frame_spacing", frame_starts[i] - frame_starts[i-1], 11);
        rd(A_STAT, 32'hC, "status_ovf_sticky");
        wr(A_STAT, 32'h7);
        rd(A_STAT, 32'hC, "status_ovf_not_cleared");
        wr(A_STAT, 32'h8);
        rd(A_STAT, 32'h4, "status_ovf_cleared");

        // Full FIFO with a write landing on the serialiser's pop edge
        for (int i = 0; i < 5; i++) wr(A_DATA, 32'h10 + i);
        for (int k = 0; k < 50 && m_cyc < m_free_at - 1; k++) idle();
        wr(A_DATA, 32'hEE);
        rd(A_STAT, 32'h39, "status_full_pop");
        wait_idle();
        wr(A_STAT, 32'h8);

        // Randomised traffic
        for (int it = 0; it < 20; it++) begin
            wait_idle();
            if ($urandom_range(0, 1) == 1) wr(A_STAT, 32'h8);
            b = $urandom_range(0, 3);
            wr(A_BAUD, b | ($urandom & 32'hFFFF_0000));
            rd(A_BAUD, b, "baud_readback");
            nb = $urandom_range(1, 7);
            for (int j = 0; j < nb; j++) begin
                wr(A_DATA | $urandom_range(0, 3), $urandom);
                gaps = $urandom_range(0, 3);
                for (int g = 0; g < gaps; g++) begin
                    case ($urandom_range(0, 4))
                        0: idle();
                        1: begin rd(A_STAT | $urandom_range(0, 3), m_status(), "status_rand"); idle(); end
                        2: wr(A_RSV, $urandom);
                        3: begin rd(A_DATA, 32'h0, "data_read_zero"); rd(A_RSV, 32'h0, "rsv_read_zero"); idle(); end
                        default: wr(BASE + 32'h40, $urandom);
                    endcase
                end
            end
            rd(A_STAT, m_status(), "status_after_burst");
        end
        wait_idle();
        wr(A_STAT, 32'h8);

        // Divisor change inside data bit 2: bit 2 keeps 4 clocks, later bits take 8
        wr(A_BAUD, 32'd3);
        wr(A_DATA, 32'h3C);
        idle();
        p = m_last_pop;
        for (int k = 0; k < 50 && m_cyc < p + 12; k++) idle();
        wr(A_BAUD, 32'd7);
        m_free_at = m_free_at + 6 * 4;
        rd(A_BAUD, 32'h7, "baud_midframe");
        wait_idle();

        // Asynchronous reset mid-bit with three bytes still queued
        wr(A_BAUD, 32'd3);
        for (int i = 0; i < 4; i++) wr(A_DATA, 32'h0);
        for (int k = 0; k < 50 && m_cyc < m_last_pop + 10; k++) idle();
        chk_b("tx_low_before_reset", uart_tx, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_b("tx_async_reset", uart_tx, 1'b1);
        chk_b("irq_async_reset", irq, 1'b1);
        model_reset();
        rd(A_STAT, 32'h4, "status_in_reset");
        rd(A_BAUD, 32'(DEF_DIV), "baud_in_reset");
        repeat (3) idle();
        rst_n = 1'b1;
        repeat (60) idle();
        rd(A_STAT, 32'h4, "status_after_reset");
        rd(A_BAUD, 32'(DEF_DIV), "baud_after_reset");

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
